// File: rtl/decrypt.sv
`default_nettype none
// ============================================================================
// Module : decrypt
// Brief  : Iterative DES (FIPS 46-3) decryption core, one Feistel round per clock.
// Rev    : 1.0  initial release
// ============================================================================

module decrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:64] cip_text1,
    input  logic [1:48] key1,
    input  logic [1:48] key2,
    input  logic [1:48] key3,
    input  logic [1:48] key4,
    input  logic [1:48] key5,
    input  logic [1:48] key6,
    input  logic [1:48] key7,
    input  logic [1:48] key8,
    input  logic [1:48] key9,
    input  logic [1:48] key10,
    input  logic [1:48] key11,
    input  logic [1:48] key12,
    input  logic [1:48] key13,
    input  logic [1:48] key14,
    input  logic [1:48] key15,
    input  logic [1:48] key16,
    output logic [1:64] cip_text2,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_run  = 1'b1;

    localparam int c_ip [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int c_fp [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int c_e [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int c_p [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    // Each S-box is stored row-major: entry index = {b1, b6, b2..b5}.
    localparam int c_sbox [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

    function automatic logic [1:64] f_ip(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[c_ip[i]];
        return y;
    endfunction

    function automatic logic [1:64] f_fp(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[c_fp[i]];
        return y;
    endfunction

    function automatic logic [1:32] f_feistel(input logic [1:32] r, input logic [1:48] k);
        logic [1:48] x;
        logic [1:32] s;
        logic [1:32] p;
        logic [5:0]  six;
        for (int i = 0; i < 48; i++) x[i+1] = r[c_e[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[6*b+1 +: 6];
            s[4*b+1 +: 4] = 4'(c_sbox[b][{six[5], six[0], six[4:1]}]);
        end
        for (int i = 0; i < 32; i++) p[i+1] = s[c_p[i]];
        return p;
    endfunction

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:32] l_q, l_d;
    logic [1:32] r_q, r_d;
    logic [1:64] cip_text2_q, cip_text2_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [1:48] w_keys [16];
    logic [1:48] w_key;
    logic [1:64] w_ip;
    logic [1:32] w_r_next;

    assign w_keys = '{key1, key2, key3, key4, key5, key6, key7, key8,
                      key9, key10, key11, key12, key13, key14, key15, key16};
    // Round cnt+1 uses K(16-cnt): the schedule is walked backwards.
    assign w_key    = w_keys[4'd15 - cnt_q];
    assign w_ip     = f_ip(cip_text1);
    assign w_r_next = l_q ^ f_feistel(r_q, w_key);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        l_d         = l_q;
        r_d         = r_q;
        cip_text2_d = cip_text2_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            c_idle: begin
                if (start) begin
                    l_d     = w_ip[1:32];
                    r_d     = w_ip[33:64];
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = c_run;
                end
            end
            c_run: begin
                l_d   = r_q;
                r_d   = w_r_next;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cip_text2_d = f_fp({w_r_next, r_q});
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = c_idle;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_idle;
            cnt_q       <= 4'd0;
            l_q         <= 32'h0;
            r_q         <= 32'h0;
            cip_text2_q <= 64'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            l_q         <= l_d;
            r_q         <= r_d;
            cip_text2_q <= cip_text2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cip_text2 = cip_text2_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_decrypt.sv
`default_nettype none
// ============================================================================
// Module : tb_decrypt
// Brief  : Self-checking bench for decrypt: known-answer table, corner-case
//          sequences and random vectors against a software DES model.
// Rev    : 1.0  initial release
// ============================================================================

module tb_decrypt;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SBOX_T [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

    typedef struct {
        logic [63:0] key;
        logic [63:0] ct;
        logic [63:0] pt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] cip_text1;
    logic [47:0] sk [16];
    logic [63:0] cip_text2;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_errors;
    logic [63:0] last_exp;

    decrypt dut (
        .clk(clk), .rst(rst), .start(start), .cip_text1(cip_text1),
        .key1(sk[0]),   .key2(sk[1]),   .key3(sk[2]),   .key4(sk[3]),
        .key5(sk[4]),   .key6(sk[5]),   .key7(sk[6]),   .key8(sk[7]),
        .key9(sk[8]),   .key10(sk[9]),  .key11(sk[10]), .key12(sk[11]),
        .key13(sk[12]), .key14(sk[13]), .key15(sk[14]), .key16(sk[15]),
        .cip_text2(cip_text2), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit n of a DES quantity (1-based, MSB first) lives at index width-n here.
    task automatic make_keys(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFT_T[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) sk[r][47-i] = cd[56-PC2_T[i]];
        end
    endtask

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] p;
        int          six;
        int          row;
        int          col;
        for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
        e = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six = int'(e[47-6*b -: 6]);
            row = (six / 32) * 2 + (six % 2);
            col = (six / 2) % 16;
            s[31-4*b -: 4] = 4'(SBOX_T[b][row*16 + col]);
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
        return p;
    endfunction

    // Encryption with the current subkeys; the final permutation is IP inverted.
    function automatic logic [63:0] des_encrypt(input logic [63:0] blk);
        logic [63:0] t;
        logic [63:0] pre;
        logic [63:0] res;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] tmp;
        for (int i = 0; i < 64; i++) t[63-i] = blk[64-IP_T[i]];
        l = t[63:32];
        r = t[31:0];
        for (int rd = 0; rd < 16; rd++) begin
            tmp = r;
            r   = l ^ feistel(r, sk[rd]);
            l   = tmp;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[64-IP_T[i]] = pre[63-i];
        return res;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One full operation; mask[i] holds start high for the edge executing round i.
    task automatic do_op(input logic [63:0] ct, input logic [63:0] exp,
                         input logic [31:0] mask, input string nm);
        int lat;
        int nbusy;
        int nhold;
        lat   = 0;
        nbusy = 0;
        nhold = 0;
        @(negedge clk);
        cip_text1 = ct;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cip_text1 = ~ct;
        chk({nm, "_busy_rise"}, 64'(busy), 64'd1);
        chk({nm, "_done_single"}, 64'(done), 64'd0);
        if (busy === 1'b1) nbusy++;
        if (cip_text2 !== last_exp) nhold++;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            start = (i < 32) ? mask[i] : 1'b0;
            @(posedge clk);
            #1;
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) lat = i;
            else if (cip_text2 !== last_exp) nhold++;
        end
        start = 1'b0;
        chk({nm, "_latency"}, 64'(lat), 64'd16);
        chk({nm, "_busy_cycles"}, 64'(nbusy), 64'd16);
        chk({nm, "_hold"}, 64'(nhold), 64'd0);
        chk({nm, "_result"}, cip_text2, exp);
        last_exp = exp;
    endtask

    initial begin
        vec_t        vecs [4];
        logic [63:0] key;
        logic [63:0] pt;
        logic [63:0] ct;
        int          cnt;
        int          hold_bad;

        vecs[0] = '{key: 64'h133457799BBCDFF1, ct: 64'h85E813540F0AB405, pt: 64'h0123456789ABCDEF};
        vecs[1] = '{key: 64'h0000000000000000, ct: 64'h8CA64DE9C1B123A7, pt: 64'h0000000000000000};
        vecs[2] = '{key: 64'hFFFFFFFFFFFFFFFF, ct: 64'h7359B2163E4EDC58, pt: 64'hFFFFFFFFFFFFFFFF};
        vecs[3] = '{key: 64'h0E329232EA6D0D73, ct: 64'h0000000000000000, pt: 64'h8787878787878787};

        n_checks  = 0;
        n_errors  = 0;
        last_exp  = 64'h0;
        rst       = 1'b1;
        start     = 1'b0;
        cip_text1 = 64'h0;
        make_keys(64'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", cip_text2, 64'h0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst = 1'b0;

        // Known-answer table; row 0 also checks the published subkey values.
        make_keys(vecs[0].key);
        chk("ks_k1", sk[0], 48'h1B02EFFC7072);
        chk("ks_k16", sk[15], 48'hCB3D8B0E17F5);
        for (int v = 0; v < 4; v++) begin
            make_keys(vecs[v].key);
            do_op(vecs[v].ct, vecs[v].pt, 32'h0, $sformatf("kat%0d", v));
        end

        make_keys(vecs[0].key);
        do_op(vecs[0].ct, vecs[0].pt, 32'h0, "kat_std");

        // Idle input change without start.
        @(negedge clk);
        cip_text1 = 64'hFFFFFFFFFFFFFFFF;
        cnt       = 0;
        hold_bad  = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) cnt++;
            if (cip_text2 !== 64'h0123456789ABCDEF) hold_bad++;
        end
        chk("idle_no_done", 64'(cnt), 64'd0);
        chk("idle_hold", 64'(hold_bad), 64'd0);

        // start pulses during rounds 3 and 10, then a back-to-back op.
        do_op(vecs[0].ct, vecs[0].pt, 32'h0000_0408, "busy_start");
        do_op(vecs[0].ct, vecs[0].pt, 32'h0, "back2back");

        // Abort at round 8.
        @(negedge clk);
        cip_text1 = vecs[0].ct;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_exp = 64'h0;
        chk("abort_out", cip_text2, 64'h0);
        chk("abort_busy", 64'(busy), 64'd0);
        cnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) cnt++;
        end
        chk("abort_no_done", 64'(cnt), 64'd0);
        do_op(vecs[0].ct, vecs[0].pt, 32'h0, "after_abort");

        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom};
            pt  = {$urandom, $urandom};
            make_keys(key);
            ct = des_encrypt(pt);
            do_op(ct, pt, (n % 7 == 0) ? 32'($urandom) & 32'h0000_FFFE : 32'h0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
